binary_adder_lookahead: RTL and testbench
=========================================

// Module: binary_adder_lookahead
// PURPOSE
//   Registered carry-lookahead binary adder: S = A + B + cin, full carry-out kept as S MSB.
//   Carries come from two-level generate/propagate lookahead, not a ripple chain.
//   Datapath leaf used wherever a low-depth add with a registered result is needed.
// PARAMETERS
//   WIDTH   4   operand width in bits; any integer >= 1 (non-multiple-of-4 pads top group)
// PORTS
//   clk   input   1         rising-edge clock
//   rst   input   1         asynchronous, active-high reset
//   cin   input   1         carry-in
//   A     input   WIDTH     unsigned operand A
//   B     input   WIDTH     unsigned operand B
//   S     output  WIDTH+1   registered sum; S[WIDTH] = carry-out
// BEHAVIOUR
//   - One clock, clk; reset is asynchronous and active-high (rst).
//   - rst=1: S forced to 0 immediately, independent of clk; held while rst=1.
//   - First rising clk edge after rst deasserts captures the current sum.
//   - Per bit: p[i]=A[i]^B[i], g[i]=A[i]&B[i]; c[0]=cin.
//   - Level 1: bits grouped in 4s (group k = bits 4k..4k+3).
//     Carries inside a group are flattened sum-of-products of g/p and group carry-in.
//     Example: c1=g0|p0c0; c2=g1|p1g0|p1p0c0; and so on.
//   - Group signals: GP = &p[group]; GG = g3|p3g2|p3p2g1|p3p2p1g0.
//   - Level 2: group carry-ins come from a lookahead over GG/GP, same form as level 1.
//     Bits above WIDTH in the top group are tied to p=0, g=0.
//   - Sum: s[i]=p[i]^c[i]; carry-out = c[WIDTH].
//   - Register: S <= {c[WIDTH], s[WIDTH-1:0]} on every rising clk edge (no enable).
//   - Latency: exactly 1 cycle from input change to S; throughput 1 add/cycle.
//   - Arithmetic: unsigned, exact, no saturation.
//     All-ones + all-ones + cin=1 gives S = 2^(WIDTH+1)-1, with no overflow beyond WIDTH+1 bits.
//   - Inputs changing between edges have no effect on S until the next edge.
//     Comb path is glitch-tolerant by design.
//   - X/Z on inputs is not handled specially.
//   - rst asserted mid-stream: S goes to 0 asynchronously.
//     The in-flight sum is discarded, not replayed.
// CONFIGURATION
//   BINARY_ADDER_LOOKAHEAD_OVF_EN defined:
//     - Adds output port ovf (1 bit), registered alongside S, reset to 0 by rst.
//     - ovf = c[WIDTH] ^ c[WIDTH-1], the two's-complement signed overflow of A+B+cin.
//   BINARY_ADDER_LOOKAHEAD_OVF_EN not defined:
//     - ovf port and its register are absent; all other behaviour identical.
// TESTING (WIDTH=4)
//   1) rst=1 with A=4'hF, B=4'hF, cin=1, clk toggling -> S=5'b00000 throughout.
//      Release rst, one edge -> S=5'd31.
//   2) cin=0, A=4'b0001, B=4'b0001 -> S=5'b00010 after 1 edge; 0010+0010 -> 5'b00100.
//   3) cin=0, A=4'b0100, B=4'b0100 -> S=5'b01000; A=4'b1001, B=4'b1001 -> S=5'b10010 (carry-out).
//   4) Full-propagate chain: A=4'b1111, B=4'b0000, cin=1 -> S=5'b10000.
//      Same with cin=0 -> S=5'b01111.
//   5) Exhaustive 512 combos of A, B, cin (plus random at WIDTH=16):
//      S must equal A+B+cin one edge later.
//      With OVF_EN, ovf must equal signed overflow (e.g. 0111+0001 -> ovf=1).
//   6) Assert rst between edges while S=18 -> S=0 before next edge.
//      Deassert -> next edge shows current sum.

Source files
------------

// File: rtl/binary_adder_lookahead.sv
// Registered two-level carry-lookahead adder: S = A + B + cin, S[WIDTH] is carry-out.
// Optional macro BINARY_ADDER_LOOKAHEAD_OVF_EN adds a registered signed-overflow output ovf.
module binary_adder_lookahead #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cin,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH:0]   S
`ifdef BINARY_ADDER_LOOKAHEAD_OVF_EN
    ,
    output logic             ovf
`endif
);

    // Only complete groups feed the level-2 lookahead; carries in a partial top
    // group are formed inside the group, which equals padding with p=0, g=0.
    localparam int unsigned NC  = WIDTH / 4;
    localparam int unsigned NGA = (NC == 0) ? 1 : NC;

    logic [WIDTH-1:0] p, g;
    logic [NGA-1:0]   gp, gg;
    logic [NC:0]      cg;
    logic [WIDTH:0]   c;
    logic [WIDTH:0]   s_d, s_q;

    always_comb begin
        logic t;
        logic acc;
        int unsigned base;
        t    = 1'b0;
        acc  = 1'b0;
        base = 0;
        p    = A ^ B;
        g    = A & B;
        gp   = '0;
        gg   = '0;

        for (int unsigned k = 0; k < NC; k++) begin
            gp[k] = &p[4*k +: 4];
            acc   = 1'b0;
            for (int unsigned m = 0; m < 4; m++) begin
                t = g[4*k+m];
                for (int unsigned n = m + 1; n < 4; n++) t = t & p[4*k+n];
                acc = acc | t;
            end
            gg[k] = acc;
        end

        cg[0] = cin;
        for (int unsigned k = 1; k <= NC; k++) begin
            acc = 1'b0;
            for (int unsigned m = 0; m < k; m++) begin
                t = gg[m];
                for (int unsigned n = m + 1; n < k; n++) t = t & gp[n];
                acc = acc | t;
            end
            t = cin;
            for (int unsigned n = 0; n < k; n++) t = t & gp[n];
            cg[k] = acc | t;
        end

        // Group-boundary carries come from level 2; the rest are flattened in-group SOPs.
        c[0] = cin;
        for (int unsigned i = 1; i <= WIDTH; i++) begin
            if (i % 4 == 0) begin
                c[i] = cg[i/4];
            end else begin
                base = (i / 4) * 4;
                acc  = 1'b0;
                for (int unsigned m = base; m < i; m++) begin
                    t = g[m];
                    for (int unsigned n = m + 1; n < i; n++) t = t & p[n];
                    acc = acc | t;
                end
                t = cg[i/4];
                for (int unsigned n = base; n < i; n++) t = t & p[n];
                c[i] = acc | t;
            end
        end

        s_d        = '0;
        s_d[WIDTH] = c[WIDTH];
        for (int unsigned i = 0; i < WIDTH; i++) s_d[i] = p[i] ^ c[i];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) s_q <= '0;
        else     s_q <= s_d;
    end

    assign S = s_q;

`ifdef BINARY_ADDER_LOOKAHEAD_OVF_EN
    logic ovf_d, ovf_q;
    assign ovf_d = c[WIDTH] ^ c[WIDTH-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ovf_q <= 1'b0;
        else     ovf_q <= ovf_d;
    end

    assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_binary_adder_lookahead.sv
// Scoreboard bench for binary_adder_lookahead at WIDTH=4 (exhaustive) and WIDTH=16 (random).
module tb_binary_adder_lookahead;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cin4 = 1'b0, cin16 = 1'b0;
    logic [3:0]  a4 = '0, b4 = '0;
    logic [15:0] a16 = '0, b16 = '0;
    logic [4:0]  s4;
    logic [16:0] s16;
    logic        ovf4, ovf16;
    logic        in_valid = 1'b0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [16:0] s;
        logic        ovf;
    } exp_t;

    exp_t q4[$];
    exp_t q16[$];

    always #5 clk = ~clk;

    binary_adder_lookahead #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .cin(cin4), .A(a4), .B(b4), .S(s4)
`ifdef BINARY_ADDER_LOOKAHEAD_OVF_EN
        , .ovf(ovf4)
`endif
    );

    binary_adder_lookahead #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .cin(cin16), .A(a16), .B(b16), .S(s16)
`ifdef BINARY_ADDER_LOOKAHEAD_OVF_EN
        , .ovf(ovf16)
`endif
    );

`ifndef BINARY_ADDER_LOOKAHEAD_OVF_EN
    assign ovf4  = 1'b0;
    assign ovf16 = 1'b0;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic, signed range test for overflow.
    function automatic exp_t model(input int unsigned w, input longint unsigned a,
                                   input longint unsigned b, input bit ci);
        exp_t e;
        longint sa, sb, sum, lim;
        lim   = longint'(1) << (w - 1);
        e.s   = 17'(a + b + longint'(ci));
        sa    = (a >= lim) ? longint'(a) - 2 * lim : longint'(a);
        sb    = (b >= lim) ? longint'(b) - 2 * lim : longint'(b);
        sum   = sa + sb + longint'(ci);
        e.ovf = (sum >= lim) || (sum < -lim);
        return e;
    endfunction

    task automatic issue(input logic [3:0] a, input logic [3:0] b, input logic ci);
        @(negedge clk);
        a4    = a;
        b4    = b;
        cin4  = ci;
        a16   = 16'($urandom);
        b16   = 16'($urandom);
        cin16 = 1'($urandom);
        in_valid = 1'b1;
        q4.push_back(model(4, 64'(a), 64'(b), ci));
        q16.push_back(model(16, 64'(a16), 64'(b16), cin16));
    endtask

    task automatic drain();
        int n;
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while ((q4.size() != 0 || q16.size() != 0) && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk("drain4", 32'(q4.size()), 32'd0);
        chk("drain16", 32'(q16.size()), 32'd0);
    endtask

    // Monitor: inputs presented before this edge appear on S just after it.
    initial begin
        forever begin
            logic cap;
            exp_t e;
            @(posedge clk);
            cap = in_valid;
            #1;
            if (cap && !rst) begin
                if (q4.size() == 0 || q16.size() == 0) begin
                    chk("sb_underflow", 32'd1, 32'd0);
                end else begin
                    e = q4.pop_front();
                    chk("sum4", 32'(s4), 32'(e.s[4:0]));
`ifdef BINARY_ADDER_LOOKAHEAD_OVF_EN
                    chk("ovf4", 32'(ovf4), 32'(e.ovf));
`endif
                    e = q16.pop_front();
                    chk("sum16", 32'(s16), 32'(e.s));
`ifdef BINARY_ADDER_LOOKAHEAD_OVF_EN
                    chk("ovf16", 32'(ovf16), 32'(e.ovf));
`endif
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset holds S at zero while clocks run with a maximal sum on the inputs.
        a4 = 4'hF; b4 = 4'hF; cin4 = 1'b1;
        a16 = 16'hFFFF; b16 = 16'hFFFF; cin16 = 1'b1;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_s4", 32'(s4), 32'd0);
            chk("rst_s16", 32'(s16), 32'd0);
            chk("rst_ovf4", 32'(ovf4), 32'd0);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rel_s4", 32'(s4), 32'd31);
        chk("rel_s16", 32'(s16), 32'h1FFFF);

        issue(4'b0001, 4'b0001, 1'b0);
        issue(4'b0010, 4'b0010, 1'b0);
        issue(4'b0100, 4'b0100, 1'b0);
        issue(4'b1001, 4'b1001, 1'b0);
        issue(4'b1111, 4'b0000, 1'b1);
        issue(4'b1111, 4'b0000, 1'b0);
        issue(4'b0111, 4'b0001, 1'b0);
        issue(4'b1000, 4'b1000, 1'b0);
        for (int unsigned v = 0; v < 512; v++) begin
            logic [8:0] vv;
            vv = 9'(v);
            issue(vv[3:0], vv[7:4], vv[8]);
        end
        drain();

        // Mid-cycle reset discards the held sum; release shows the current one.
        issue(4'd9, 4'd9, 1'b0);
        drain();
        chk("pre_rst_s4", 32'(s4), 32'd18);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk("async_rst_s4", 32'(s4), 32'd0);
        chk("async_rst_s16", 32'(s16), 32'd0);
        a4 = 4'd3; b4 = 4'd4; cin4 = 1'b0;
        a16 = 16'd1000; b16 = 16'd2345; cin16 = 1'b1;
        #2;
        rst = 1'b0;
        chk("held_s4", 32'(s4), 32'd0);
        @(posedge clk); #1;
        chk("post_rst_s4", 32'(s4), 32'd7);
        chk("post_rst_s16", 32'(s16), 32'd3346);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
